// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM stage of the 5-stage MIPS pipeline:
//   - bus widths of the EXE->MEM and MEM->WB pipeline buses
//   - field offsets inside both buses
//   - result selection helper (load data vs. ALU result)
// No ports (package).
// -----------------------------------------------------------------------------
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD = 76;
   localparam int MS_TO_WS_BUS_WD = 75;

   // EXE->MEM bus field positions
   localparam int ES_EXCODE_MSB   = 75;
   localparam int ES_EXCODE_LSB   = 71;
   localparam int ES_RES_MEM_BIT  = 70;
   localparam int ES_GR_WE_BIT    = 69;
   localparam int ES_DEST_MSB     = 68;
   localparam int ES_DEST_LSB     = 64;
   localparam int ES_ALU_MSB      = 63;
   localparam int ES_ALU_LSB      = 32;
   localparam int ES_PC_MSB       = 31;
   localparam int ES_PC_LSB       = 0;

   // MEM->WB bus field positions
   localparam int WS_EXCODE_MSB   = 74;
   localparam int WS_EXCODE_LSB   = 70;
   localparam int WS_GR_WE_BIT    = 69;
   localparam int WS_DEST_MSB     = 68;
   localparam int WS_DEST_LSB     = 64;
   localparam int WS_RESULT_MSB   = 63;
   localparam int WS_RESULT_LSB   = 32;
   localparam int WS_PC_MSB       = 31;
   localparam int WS_PC_LSB       = 0;

   // Loads return memory data, everything else forwards the ALU result.
   function automatic logic [31:0] pick_result(input logic        res_from_mem,
                                               input logic [31:0] load_data,
                                               input logic [31:0] alu_result);
      return res_from_mem ? load_data : alu_result;
   endfunction

endpackage

// File: rtl/ms_rdata_hold.sv
// -----------------------------------------------------------------------------
// ms_rdata_hold
// Keeps SRAM read data alive while the consumer stalls. The SRAM returns data
// only in the cycle after the address was issued, so if the downstream stage
// cannot accept the entry in that first cycle the data is parked in a buffer
// and served from there until the entry leaves.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   flush         kills the held entry (clears flag and buffer)
//   capture       a new entry is being latched this cycle
//   entry_valid   the owning stage holds a valid entry
//   ws_allowin    downstream can accept this cycle
//   leave         the entry transfers downstream this cycle
//   rdata         raw SRAM read data
//   load_data     stable read data for the current entry
// -----------------------------------------------------------------------------
module ms_rdata_hold (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        capture,
   input  logic        entry_valid,
   input  logic        ws_allowin,
   input  logic        leave,
   input  logic [31:0] rdata,
   output logic [31:0] load_data
);

   logic        first_cycle;
   logic        buf_valid;
   logic [31:0] rdata_buf;
   logic        hold_now;

   // The only cycle where SRAM data belongs to this entry is the first one;
   // park it if the entry cannot leave right then.
   assign hold_now = first_cycle && entry_valid && !ws_allowin;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         first_cycle <= 1'b0;
      end else begin
         first_cycle <= capture;
      end
   end

   // hold_now needs !ws_allowin while leave needs ws_allowin, so they are
   // mutually exclusive; a leave+enter cycle therefore clears the buffer.
   always_ff @(posedge clk) begin
      if (reset || flush || leave) begin
         buf_valid <= 1'b0;
      end else if (hold_now) begin
         buf_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (hold_now) begin
         rdata_buf <= rdata;
      end
   end

   assign load_data = buf_valid ? rdata_buf : rdata;

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 5-stage MIPS pipeline. Latches the EXE bundle,
// picks the final result (load data for loads, ALU result otherwise), hands it
// to WB with a valid/allowin handshake and exposes bypass info to decode.
// SRAM read data is held across WB back-pressure by ms_rdata_hold.
// Optional feature macro: MS_PERF_CNT_EN adds load/stall performance counters.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               exception flush, kills the in-flight entry
//   ws_allowin          WB can accept this cycle
//   ms_allowin          MEM can accept this cycle
//   es_to_ms_valid/bus  EXE->MEM bundle
//   data_sram_rdata     SRAM read data (valid the cycle after address issue)
//   ms_to_ws_valid/bus  MEM->WB bundle
//   ms_dest             bypass destination (0 if invalid or no write)
//   ms_to_ds_result     bypass value
//   perf_load_cnt       (MS_PERF_CNT_EN) loads transferred to WB
//   perf_stall_cnt      (MS_PERF_CNT_EN) cycles stalled by WB
// -----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ES_BUS_WD = ES_TO_MS_BUS_WD,
   parameter int WS_BUS_WD = MS_TO_WS_BUS_WD
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 ws_allowin,
   output logic                 ms_allowin,
   input  logic                 es_to_ms_valid,
   input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
   input  logic [31:0]          data_sram_rdata,
   output logic                 ms_to_ws_valid,
   output logic [WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [4:0]           ms_dest,
   output logic [31:0]          ms_to_ds_result
`ifdef MS_PERF_CNT_EN
   ,
   output logic [31:0]          perf_load_cnt,
   output logic [31:0]          perf_stall_cnt
`endif
);

   logic                 ms_valid;
   logic                 ms_ready_go;
   logic [ES_BUS_WD-1:0] es_bus_r;
   logic                 capture;
   logic                 leave;

   logic [4:0]           ms_excode;
   logic                 ms_res_from_mem;
   logic                 ms_gr_we;
   logic [4:0]           ms_dest_field;
   logic [31:0]          ms_alu_result;
   logic [31:0]          ms_pc;
   logic [31:0]          load_data;
   logic [31:0]          final_result;

   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;
   assign capture        = es_to_ms_valid && ms_allowin;
   assign leave          = ms_to_ws_valid && ws_allowin;

   // ---- EXE -> MEM boundary ----
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid;
      end
   end

   // A flushed capture still loads the register; ms_valid=0 masks it.
   always_ff @(posedge clk) begin
      if (capture) begin
         es_bus_r <= es_to_ms_bus;
      end
   end

   assign ms_excode       = es_bus_r[ES_EXCODE_MSB:ES_EXCODE_LSB];
   assign ms_res_from_mem = es_bus_r[ES_RES_MEM_BIT];
   assign ms_gr_we        = es_bus_r[ES_GR_WE_BIT];
   assign ms_dest_field   = es_bus_r[ES_DEST_MSB:ES_DEST_LSB];
   assign ms_alu_result   = es_bus_r[ES_ALU_MSB:ES_ALU_LSB];
   assign ms_pc           = es_bus_r[ES_PC_MSB:ES_PC_LSB];

   ms_rdata_hold u_rdata_hold (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .capture     (capture),
      .entry_valid (ms_valid),
      .ws_allowin  (ws_allowin),
      .leave       (leave),
      .rdata       (data_sram_rdata),
      .load_data   (load_data)
   );

   assign final_result = pick_result(ms_res_from_mem, load_data, ms_alu_result);

   // ---- MEM -> WB boundary ----
   assign ms_to_ws_bus    = {ms_excode, ms_gr_we, ms_dest_field, final_result, ms_pc};
   assign ms_dest         = (ms_valid && ms_gr_we) ? ms_dest_field : 5'd0;
   assign ms_to_ds_result = final_result;

`ifdef MS_PERF_CNT_EN
   // Counters ignore flush: they measure pipeline activity, not retirement.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_load_cnt  <= 32'd0;
         perf_stall_cnt <= 32'd0;
      end else begin
         if (leave && ms_res_from_mem) begin
            perf_load_cnt <= perf_load_cnt + 32'd1;
         end
         if (ms_valid && !ws_allowin) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
